// File: rtl/if_id_dual_reg_if.sv
// Fetch/hazard/decode bundle for the dual-slot IF/ID register.
// Perf counter signals exist only when IF_ID_PERF_COUNT_EN is defined.
`ifndef NUM_PIPE_MASKS
`define NUM_PIPE_MASKS 5
`endif
`ifndef PIPE_REG_PC
`define PIPE_REG_PC 0
`endif
`ifndef PIPE_REG_IF_ID
`define PIPE_REG_IF_ID 1
`endif
`ifndef PIPE_REG_ID_EX
`define PIPE_REG_ID_EX 2
`endif
`ifndef OP_CODE_BITS
`define OP_CODE_BITS 6
`endif
`ifndef OP_CODE_NOP
`define OP_CODE_NOP 6'h3f
`endif
`ifndef NUM_REGISTERS_LOG2
`define NUM_REGISTERS_LOG2 5
`endif

interface if_id_dual_reg_if #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned PC_WIDTH = 16
);
    logic                             flush;
    logic [WIDTH-1:0]                 fetch_instr0, fetch_instr1;
    logic [PC_WIDTH-1:0]              fetch_pc0, fetch_pc1;
    logic                             fetch_first;
    logic [`NUM_PIPE_MASKS-1:0]       stall0, stall1, nop0, nop1;
    logic                             clear0, clear1;
    logic [WIDTH-1:0]                 if_id_instr0, if_id_instr1;
    logic [PC_WIDTH-1:0]              if_id_pc0, if_id_pc1;
    logic [`OP_CODE_BITS-1:0]         if_id_opcode0, if_id_opcode1;
    logic [`NUM_REGISTERS_LOG2-1:0]   if_id_rs0, if_id_rs1, if_id_rt0, if_id_rt1;
    logic [`NUM_REGISTERS_LOG2-1:0]   if_id_rd0, if_id_rd1;
    logic                             if_id_valid0, if_id_valid1;
    logic                             first;
`ifdef IF_ID_PERF_COUNT_EN
    logic [31:0]                      perf_stall_cycles, perf_split_issues;
`endif

    modport master (
`ifdef IF_ID_PERF_COUNT_EN
        input  perf_stall_cycles, perf_split_issues,
`endif
        output flush, fetch_instr0, fetch_instr1, fetch_pc0, fetch_pc1, fetch_first,
        output stall0, stall1, nop0, nop1, clear0, clear1,
        input  if_id_instr0, if_id_instr1, if_id_pc0, if_id_pc1,
        input  if_id_opcode0, if_id_opcode1, if_id_rs0, if_id_rs1, if_id_rt0, if_id_rt1,
        input  if_id_rd0, if_id_rd1, if_id_valid0, if_id_valid1, first
    );

    modport slave (
`ifdef IF_ID_PERF_COUNT_EN
        output perf_stall_cycles, perf_split_issues,
`endif
        input  flush, fetch_instr0, fetch_instr1, fetch_pc0, fetch_pc1, fetch_first,
        input  stall0, stall1, nop0, nop1, clear0, clear1,
        output if_id_instr0, if_id_instr1, if_id_pc0, if_id_pc1,
        output if_id_opcode0, if_id_opcode1, if_id_rs0, if_id_rs1, if_id_rt0, if_id_rt1,
        output if_id_rd0, if_id_rd1, if_id_valid0, if_id_valid1, first
    );
endinterface

// File: rtl/if_id_dual_reg.sv
// Dual-slot IF/ID pipeline register with per-slot stall/nop/clear and field decode.
// Optional hazard perf counters are built when IF_ID_PERF_COUNT_EN is defined.
`ifndef NUM_PIPE_MASKS
`define NUM_PIPE_MASKS 5
`endif
`ifndef PIPE_REG_IF_ID
`define PIPE_REG_IF_ID 1
`endif
`ifndef OP_CODE_BITS
`define OP_CODE_BITS 6
`endif
`ifndef OP_CODE_NOP
`define OP_CODE_NOP 6'h3f
`endif
`ifndef NUM_REGISTERS_LOG2
`define NUM_REGISTERS_LOG2 5
`endif

module if_id_dual_reg #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned PC_WIDTH = 16
) (
    input logic               clk,
    input logic               reset,
    if_id_dual_reg_if.slave   bus
);
    localparam logic [`OP_CODE_BITS-1:0] NopOp = `OP_CODE_NOP;
    localparam logic [WIDTH-1:0] EmptyInstr = {NopOp, {(WIDTH - `OP_CODE_BITS){1'b0}}};

    logic [WIDTH-1:0]    instr_q [2];
    logic [WIDTH-1:0]    instr_d [2];
    logic [PC_WIDTH-1:0] pc_q [2];
    logic [PC_WIDTH-1:0] pc_d [2];
    logic [1:0]          valid_q, valid_d;
    logic                first_q, first_d;

    logic [WIDTH-1:0]    fetch_instr [2];
    logic [PC_WIDTH-1:0] fetch_pc [2];
    logic [1:0]          stall_b, nop_b, clear_b, load, hold;

    always_comb begin
        fetch_instr[0] = bus.fetch_instr0;
        fetch_instr[1] = bus.fetch_instr1;
        fetch_pc[0]    = bus.fetch_pc0;
        fetch_pc[1]    = bus.fetch_pc1;
        stall_b = {bus.stall1[`PIPE_REG_IF_ID], bus.stall0[`PIPE_REG_IF_ID]};
        nop_b   = {bus.nop1[`PIPE_REG_IF_ID], bus.nop0[`PIPE_REG_IF_ID]};
        clear_b = {bus.clear1, bus.clear0};
        // Anything that empties a slot outranks the stall.
        hold = ~{2{bus.flush}} & ~clear_b & ~nop_b & stall_b;
        load = ~{2{bus.flush}} & ~clear_b & ~nop_b & ~stall_b;
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            instr_d[i] = EmptyInstr;
            pc_d[i]    = '0;
            valid_d[i] = 1'b0;
            if (load[i]) begin
                instr_d[i] = fetch_instr[i];
                pc_d[i]    = fetch_pc[i];
                valid_d[i] = 1'b1;
            end else if (hold[i]) begin
                instr_d[i] = instr_q[i];
                pc_d[i]    = pc_q[i];
                valid_d[i] = valid_q[i];
            end
        end
        // A held slot next to a freshly loaded one is the older instruction.
        first_d = first_q;
        if (bus.flush)                  first_d = 1'b0;
        else if (load[0] && load[1])    first_d = bus.fetch_first;
        else if (load[0] && hold[1])    first_d = 1'b1;
        else if (hold[0] && load[1])    first_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                instr_q[i] <= EmptyInstr;
                pc_q[i]    <= '0;
            end
            valid_q <= 2'b00;
            first_q <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                instr_q[i] <= instr_d[i];
                pc_q[i]    <= pc_d[i];
            end
            valid_q <= valid_d;
            first_q <= first_d;
        end
    end

    assign bus.if_id_instr0  = instr_q[0];
    assign bus.if_id_instr1  = instr_q[1];
    assign bus.if_id_pc0     = pc_q[0];
    assign bus.if_id_pc1     = pc_q[1];
    assign bus.if_id_opcode0 = instr_q[0][31:26];
    assign bus.if_id_opcode1 = instr_q[1][31:26];
    assign bus.if_id_rs0     = instr_q[0][25:21];
    assign bus.if_id_rs1     = instr_q[1][25:21];
    assign bus.if_id_rt0     = instr_q[0][20:16];
    assign bus.if_id_rt1     = instr_q[1][20:16];
    assign bus.if_id_rd0     = instr_q[0][15:11];
    assign bus.if_id_rd1     = instr_q[1][15:11];
    assign bus.if_id_valid0  = valid_q[0];
    assign bus.if_id_valid1  = valid_q[1];
    assign bus.first         = first_q;

    logic unused_masks;
    assign unused_masks = ^{bus.stall0, bus.stall1, bus.nop0, bus.nop1};

`ifdef IF_ID_PERF_COUNT_EN
    logic [31:0] stall_cnt_q, split_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            split_cnt_q <= '0;
        end else begin
            if (|(hold & valid_q)) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (bus.clear0 ^ bus.clear1) split_cnt_q <= split_cnt_q + 32'd1;
        end
    end

    assign bus.perf_stall_cycles = stall_cnt_q;
    assign bus.perf_split_issues = split_cnt_q;
`endif
endmodule

// File: tb/tb_if_id_dual_reg.sv
// Bench for if_id_dual_reg: directed scenarios plus randomized traffic against a slot model.
`ifndef NUM_PIPE_MASKS
`define NUM_PIPE_MASKS 5
`endif
`ifndef PIPE_REG_PC
`define PIPE_REG_PC 0
`endif
`ifndef PIPE_REG_IF_ID
`define PIPE_REG_IF_ID 1
`endif
`ifndef PIPE_REG_ID_EX
`define PIPE_REG_ID_EX 2
`endif
`ifndef OP_CODE_NOP
`define OP_CODE_NOP 6'h3f
`endif

module tb_if_id_dual_reg;
    localparam int W  = 32;
    localparam int PW = 16;
    localparam logic [5:0]  NopOp = `OP_CODE_NOP;
    localparam logic [31:0] EmptyInstr = {NopOp, 26'b0};
    localparam logic [`NUM_PIPE_MASKS-1:0] IfIdMask = 1 << `PIPE_REG_IF_ID;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    if_id_dual_reg_if #(.WIDTH(W), .PC_WIDTH(PW)) bus ();

    if_id_dual_reg #(.WIDTH(W), .PC_WIDTH(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Model state: what each slot should contain after the last edge.
    logic [31:0] m_instr [2];
    logic [15:0] m_pc [2];
    logic        m_valid [2];
    logic        m_first;
    logic [31:0] m_stall_cnt, m_split_cnt;

    task automatic model_edge();
        int  act [2];  // 0 empty, 1 hold, 2 load
        logic st [2], np [2], cl [2];
        logic [31:0] fi [2];
        logic [15:0] fp [2];
        st[0] = bus.stall0[`PIPE_REG_IF_ID]; st[1] = bus.stall1[`PIPE_REG_IF_ID];
        np[0] = bus.nop0[`PIPE_REG_IF_ID];   np[1] = bus.nop1[`PIPE_REG_IF_ID];
        cl[0] = bus.clear0;  cl[1] = bus.clear1;
        fi[0] = bus.fetch_instr0; fi[1] = bus.fetch_instr1;
        fp[0] = bus.fetch_pc0;    fp[1] = bus.fetch_pc1;
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_instr[i] = EmptyInstr; m_pc[i] = 0; m_valid[i] = 0;
            end
            m_first = 0; m_stall_cnt = 0; m_split_cnt = 0;
        end else begin
            for (int i = 0; i < 2; i++)
                act[i] = (bus.flush || cl[i] || np[i]) ? 0 : (st[i] ? 1 : 2);
            if ((act[0] == 1 && m_valid[0]) || (act[1] == 1 && m_valid[1]))
                m_stall_cnt = m_stall_cnt + 1;
            if (cl[0] != cl[1]) m_split_cnt = m_split_cnt + 1;
            if (bus.flush) m_first = 0;
            else if (act[0] == 2 && act[1] == 2) m_first = bus.fetch_first;
            else if (act[0] == 2 && act[1] == 1) m_first = 1;
            else if (act[0] == 1 && act[1] == 2) m_first = 0;
            for (int i = 0; i < 2; i++) begin
                if (act[i] == 0) begin
                    m_instr[i] = EmptyInstr; m_pc[i] = 0; m_valid[i] = 0;
                end else if (act[i] == 2) begin
                    m_instr[i] = fi[i]; m_pc[i] = fp[i]; m_valid[i] = 1;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        bus.flush = 0; bus.fetch_first = 0;
        bus.stall0 = 0; bus.stall1 = 0; bus.nop0 = 0; bus.nop1 = 0;
        bus.clear0 = 0; bus.clear1 = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        bus.fetch_instr0 = 32'h0022_1800; bus.fetch_instr1 = 32'h0443_0005;
        bus.fetch_pc0 = 16'h0100; bus.fetch_pc1 = 16'h0104;
        bus.fetch_first = 1;
        tick(); tick();
        checks++;
        if (bus.if_id_valid0 !== 0 || bus.if_id_valid1 !== 0 || bus.first !== 0) begin
            errors++;
            $display("FAIL reset_flags: got v0=%b v1=%b first=%b required 0 0 0",
                     bus.if_id_valid0, bus.if_id_valid1, bus.first);
        end
        checks++;
        if (bus.if_id_instr0 !== EmptyInstr || bus.if_id_pc1 !== 0 ||
            bus.if_id_opcode1 !== NopOp) begin
            errors++;
            $display("FAIL reset_data: got instr0=%h pc1=%h op1=%h required %h 0 %h",
                     bus.if_id_instr0, bus.if_id_pc1, bus.if_id_opcode1, EmptyInstr, NopOp);
        end
        reset = 0;
        tick();
        checks++;
        if (bus.if_id_valid0 !== 1 || bus.if_id_valid1 !== 1 || bus.first !== 1) begin
            errors++;
            $display("FAIL first_load_flags: got v0=%b v1=%b first=%b required 1 1 1",
                     bus.if_id_valid0, bus.if_id_valid1, bus.first);
        end
        checks++;
        if ({bus.if_id_rs0, bus.if_id_rt0, bus.if_id_rd0} !== {5'd1, 5'd2, 5'd3}) begin
            errors++;
            $display("FAIL slot0_decode: got rs=%0d rt=%0d rd=%0d required 1 2 3",
                     bus.if_id_rs0, bus.if_id_rt0, bus.if_id_rd0);
        end
        checks++;
        if ({bus.if_id_opcode1, bus.if_id_rs1, bus.if_id_rt1} !== {6'h01, 5'd2, 5'd3}) begin
            errors++;
            $display("FAIL slot1_decode: got op=%h rs=%0d rt=%0d required 01 2 3",
                     bus.if_id_opcode1, bus.if_id_rs1, bus.if_id_rt1);
        end
    endtask

    task automatic test_stall();
        logic [`NUM_PIPE_MASKS-1:0] m;
        m = (1 << `PIPE_REG_PC) | (1 << `PIPE_REG_IF_ID) | (1 << `PIPE_REG_ID_EX);
        bus.stall0 = m; bus.stall1 = m;
        bus.fetch_instr0 = 32'hDEAD_BEEF; bus.fetch_instr1 = 32'h1234_5678;
        bus.fetch_pc0 = 16'h0200; bus.fetch_pc1 = 16'h0204; bus.fetch_first = 0;
        tick(); tick(); tick();
        checks++;
        if (bus.if_id_instr0 !== 32'h0022_1800 || bus.if_id_instr1 !== 32'h0443_0005) begin
            errors++;
            $display("FAIL stall_instr: got %h %h required 00221800 04430005",
                     bus.if_id_instr0, bus.if_id_instr1);
        end
        checks++;
        if (bus.if_id_pc0 !== 16'h0100 || bus.if_id_pc1 !== 16'h0104 || bus.first !== 1) begin
            errors++;
            $display("FAIL stall_pc: got %h %h first=%b required 0100 0104 1",
                     bus.if_id_pc0, bus.if_id_pc1, bus.first);
        end
`ifdef IF_ID_PERF_COUNT_EN
        checks++;
        if (bus.perf_stall_cycles !== 32'd3) begin
            errors++;
            $display("FAIL stall_count: got %0d required 3", bus.perf_stall_cycles);
        end
`endif
    endtask

    task automatic test_split_issue();
        bus.stall0 = IfIdMask; bus.stall1 = 0; bus.clear1 = 1;
        tick();
        checks++;
        if (bus.if_id_valid1 !== 0 || bus.if_id_opcode1 !== NopOp ||
            bus.if_id_instr0 !== 32'h0022_1800 || bus.if_id_valid0 !== 1 || bus.first !== 1) begin
            errors++;
            $display("FAIL split_issue: got v1=%b op1=%h instr0=%h v0=%b first=%b req 0 %h 00221800 1 1",
                     bus.if_id_valid1, bus.if_id_opcode1, bus.if_id_instr0, bus.if_id_valid0,
                     bus.first, NopOp);
        end
        bus.stall0 = 0; bus.clear1 = 0;
        tick();
        checks++;
        if (bus.if_id_instr0 !== 32'hDEAD_BEEF || bus.if_id_instr1 !== 32'h1234_5678 ||
            bus.if_id_valid1 !== 1 || bus.first !== 0) begin
            errors++;
            $display("FAIL split_reload: got %h %h v1=%b first=%b required deadbeef 12345678 1 0",
                     bus.if_id_instr0, bus.if_id_instr1, bus.if_id_valid1, bus.first);
        end
`ifdef IF_ID_PERF_COUNT_EN
        checks++;
        if (bus.perf_split_issues !== 32'd1) begin
            errors++;
            $display("FAIL split_count: got %0d required 1", bus.perf_split_issues);
        end
`endif
    endtask

    task automatic test_flush();
        bus.fetch_first = 1;
        tick();
        bus.flush = 1; bus.stall0 = IfIdMask;
        tick();
        checks++;
        if (bus.if_id_valid0 !== 0 || bus.if_id_valid1 !== 0 || bus.first !== 0 ||
            bus.if_id_pc0 !== 0 || bus.if_id_instr0 !== EmptyInstr) begin
            errors++;
            $display("FAIL flush_stall: got v0=%b v1=%b first=%b pc0=%h instr0=%h required empty",
                     bus.if_id_valid0, bus.if_id_valid1, bus.first, bus.if_id_pc0,
                     bus.if_id_instr0);
        end
        idle_inputs();
    endtask

    task automatic test_reset_with_load();
        bus.fetch_first = 1;
        tick();
        reset = 1;
        tick();
        checks++;
        if (bus.if_id_valid0 !== 0 || bus.if_id_valid1 !== 0 || bus.first !== 0 ||
            bus.if_id_instr1 !== EmptyInstr || bus.if_id_pc0 !== 0) begin
            errors++;
            $display("FAIL reset_over_load: got v0=%b v1=%b first=%b instr1=%h pc0=%h",
                     bus.if_id_valid0, bus.if_id_valid1, bus.first, bus.if_id_instr1,
                     bus.if_id_pc0);
        end
`ifdef IF_ID_PERF_COUNT_EN
        checks++;
        if (bus.perf_stall_cycles !== 0 || bus.perf_split_issues !== 0) begin
            errors++;
            $display("FAIL reset_counters: got %0d %0d required 0 0",
                     bus.perf_stall_cycles, bus.perf_split_issues);
        end
`endif
        reset = 0;
    endtask

    task automatic test_random();
        logic [31:0] gi [2];
        logic [15:0] gp [2];
        logic [20:0] gf [2];
        logic        gv [2];
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 39) == 0);
            bus.flush = ($urandom_range(0, 15) == 0);
            bus.fetch_instr0 = $urandom; bus.fetch_instr1 = $urandom;
            bus.fetch_pc0 = 16'($urandom); bus.fetch_pc1 = 16'($urandom);
            bus.fetch_first = 1'($urandom);
            bus.stall0 = `NUM_PIPE_MASKS'($urandom) & ~IfIdMask;
            bus.stall1 = `NUM_PIPE_MASKS'($urandom) & ~IfIdMask;
            if ($urandom_range(0, 3) == 0) bus.stall0 = bus.stall0 | IfIdMask;
            if ($urandom_range(0, 3) == 0) bus.stall1 = bus.stall1 | IfIdMask;
            bus.nop0 = ($urandom_range(0, 7) == 0) ? IfIdMask : '0;
            bus.nop1 = ($urandom_range(0, 7) == 0) ? IfIdMask : '0;
            bus.clear0 = ($urandom_range(0, 5) == 0);
            bus.clear1 = ($urandom_range(0, 5) == 0);
            tick();
            gi[0] = bus.if_id_instr0; gi[1] = bus.if_id_instr1;
            gp[0] = bus.if_id_pc0;    gp[1] = bus.if_id_pc1;
            gv[0] = bus.if_id_valid0; gv[1] = bus.if_id_valid1;
            gf[0] = {bus.if_id_opcode0, bus.if_id_rs0, bus.if_id_rt0, bus.if_id_rd0};
            gf[1] = {bus.if_id_opcode1, bus.if_id_rs1, bus.if_id_rt1, bus.if_id_rd1};
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (gi[i] !== m_instr[i] || gp[i] !== m_pc[i] || gv[i] !== m_valid[i]) begin
                    errors++;
                    $display("FAIL rand_slot%0d cyc %0d: got %h/%h/%b required %h/%h/%b",
                             i, n, gi[i], gp[i], gv[i], m_instr[i], m_pc[i], m_valid[i]);
                end
                checks++;
                if (gf[i] !== m_instr[i][31:11]) begin
                    errors++;
                    $display("FAIL rand_decode%0d cyc %0d: got %h required %h",
                             i, n, gf[i], m_instr[i][31:11]);
                end
            end
            checks++;
            if (bus.first !== m_first) begin
                errors++;
                $display("FAIL rand_first cyc %0d: got %b required %b", n, bus.first, m_first);
            end
`ifdef IF_ID_PERF_COUNT_EN
            checks++;
            if (bus.perf_stall_cycles !== m_stall_cnt || bus.perf_split_issues !== m_split_cnt) begin
                errors++;
                $display("FAIL rand_counters cyc %0d: got %0d %0d required %0d %0d", n,
                         bus.perf_stall_cycles, bus.perf_split_issues, m_stall_cnt, m_split_cnt);
            end
`endif
        end
        reset = 0;
        idle_inputs();
    endtask

`ifdef IF_ID_PERF_COUNT_EN
    task automatic test_counter_wrap();
        idle_inputs();
        force dut.split_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.split_cnt_q;
        bus.clear0 = 1;
        tick();
        checks++;
        if (bus.perf_split_issues !== 32'd0) begin
            errors++;
            $display("FAIL split_wrap: got %h required 00000000", bus.perf_split_issues);
        end
        idle_inputs();
    endtask
`endif

    initial begin
        test_reset();
        test_stall();
        test_split_issue();
        test_flush();
        test_reset_with_load();
        test_random();
`ifdef IF_ID_PERF_COUNT_EN
        test_counter_wrap();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
